paddle_quad_encoder: RTL and testbench

//  Generates the paddle quadrature pair (Enc_A/Enc_B) for the super_breakout core from digital left/right controls.

---
 rtl/paddle_quad_encoder.sv | 201 ++++++++++++++++++++
 tb/tb_paddle_quad_encoder.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/paddle_quad_encoder.sv
// -----------------------------------------------------------------------------
// paddle_quad_encoder
//
// Produces the paddle quadrature pair (enc_a/enc_b) for the super_breakout core.
// Digital left/right controls drive a Gray-code phase walker. Its step rate
// starts at DIV_MAX clocks per step and speeds up by ACCEL_STEP after every
// step, down to DIV_MIN, for as long as one direction is held.
//
// Optional external spinner (build with `define PADDLE_QUAD_EXT_EN):
// ext_a/ext_b are synchronised and deglitched as a pair. The outputs follow
// whichever source moved last. Without the macro ext_a/ext_b are ignored and
// src_ext is tied low.
//
// Ports
//   CLK      in   system clock (12 MHz)
//   Reset_n  in   asynchronous active-low reset
//   left     in   move-left request, active high
//   right    in   move-right request, active high
//   ext_a    in   external spinner phase A (asynchronous, idle high)
//   ext_b    in   external spinner phase B (asynchronous, idle high)
//   enc_a    out  quadrature phase A to core (registered)
//   enc_b    out  quadrature phase B to core (registered)
//   src_ext  out  1 = outputs follow external spinner, 0 = left/right
//   step     out  one-cycle pulse on each joystick-path quadrature step
// -----------------------------------------------------------------------------
module paddle_quad_encoder #(
    parameter int unsigned DIV_MAX    = 5500,
    parameter int unsigned DIV_MIN    = 1375,
    parameter int unsigned ACCEL_STEP = 256,
    parameter int unsigned FILT_LEN   = 4
) (
    input  logic CLK,
    input  logic Reset_n,
    input  logic left,
    input  logic right,
    input  logic ext_a,
    input  logic ext_b,
    output logic enc_a,
    output logic enc_b,
    output logic src_ext,
    output logic step
);

    localparam int unsigned CW = $clog2(DIV_MAX + 1);
    localparam logic [CW-1:0] PERIOD_INIT = CW'(DIV_MAX);
    localparam logic [CW-1:0] PERIOD_MIN  = CW'(DIV_MIN);

    typedef enum logic [1:0] {
        DIR_IDLE  = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_LEFT  = 2'd2
    } dir_e;

    // One Gray-code step: right walks 00->01->11->10, left walks the reverse.
    function automatic logic [1:0] advance(input logic [1:0] p, input logic fwd);
        logic [1:0] r;
        case (p)
            2'b00:   r = fwd ? 2'b01 : 2'b10;
            2'b01:   r = fwd ? 2'b11 : 2'b00;
            2'b11:   r = fwd ? 2'b10 : 2'b01;
            default: r = fwd ? 2'b00 : 2'b11;
        endcase
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // Joystick path
    // -------------------------------------------------------------------------
    dir_e          dir_in;
    dir_e          dir_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] period_q, period_d;
    logic [1:0]    phase_q, phase_d;
    logic          step_q, step_d;
    logic          reversal;

    always_comb begin
        dir_in = DIR_IDLE;
        if (right && !left) dir_in = DIR_RIGHT;
        if (left && !right) dir_in = DIR_LEFT;
    end

    // A direct RIGHT<->LEFT swap acts as one idle cycle, so the new direction
    // starts again from the slowest rate.
    assign reversal = (dir_in != DIR_IDLE) && (dir_q != DIR_IDLE) && (dir_in != dir_q);

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        cnt_d    = cnt_q;
        period_d = period_q;
        phase_d  = phase_q;
        step_d   = 1'b0;
        if (dir_in == DIR_IDLE || reversal) begin
            cnt_d    = '0;
            period_d = PERIOD_INIT;
        end else if (cnt_q == period_q - CW'(1)) begin
            step_d  = 1'b1;
            cnt_d   = '0;
            phase_d = advance(phase_q, dir_in == DIR_RIGHT);
            // Saturating decrement, compared in 32 bits so a large ACCEL_STEP
            // can never wrap the period around.
            if (32'(period_q) >= DIV_MIN + ACCEL_STEP)
                period_d = period_q - CW'(ACCEL_STEP);
            else
                period_d = PERIOD_MIN;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            dir_q    <= DIR_IDLE;
            cnt_q    <= '0;
            period_q <= PERIOD_INIT;
            phase_q  <= 2'b00;
            step_q   <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the pre-edge values of its neighbours.
            dir_q    <= dir_in;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            phase_q  <= phase_d;
            step_q   <= step_d;
        end
    end

    // -------------------------------------------------------------------------
    // External spinner path and output mux
    // -------------------------------------------------------------------------
    logic [1:0] enc_q, enc_d;
    logic       src_ext_q;

`ifdef PADDLE_QUAD_EXT_EN
    localparam int unsigned FW = $clog2(FILT_LEN + 1);

    logic [1:0]    sync1_q, sync2_q;
    logic [1:0]    prev_q;
    logic [1:0]    filt_q, filt_d;
    logic [FW-1:0] run_q, run_d;
    logic          src_ext_d;

    always_comb begin
        // run_d = length of the current streak of identical samples,
        // saturating at FILT_LEN.
        run_d = FW'(1);
        if (sync2_q == prev_q)
            run_d = (run_q == FW'(FILT_LEN)) ? run_q : run_q + FW'(1);

        filt_d = filt_q;
        if (run_d == FW'(FILT_LEN) && sync2_q != filt_q)
            filt_d = sync2_q;

        // A joystick step takes the outputs back even if the spinner moved
        // in the same cycle.
        src_ext_d = src_ext_q;
        if (step_d)
            src_ext_d = 1'b0;
        else if (filt_d != filt_q)
            src_ext_d = 1'b1;
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1_q   <= 2'b11;
            sync2_q   <= 2'b11;
            prev_q    <= 2'b11;
            filt_q    <= 2'b11;
            run_q     <= '0;
            src_ext_q <= 1'b0;
        end else begin
            sync1_q   <= {ext_a, ext_b};
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            filt_q    <= filt_d;
            run_q     <= run_d;
            src_ext_q <= src_ext_d;
        end
    end

    assign enc_d = src_ext_q ? filt_q : phase_q;
`else
    logic unused_ext;
    assign unused_ext = ext_a ^ ext_b;
    assign src_ext_q  = 1'b0;
    assign enc_d      = phase_q;
`endif

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) enc_q <= 2'b00;
        else          enc_q <= enc_d;
    end

    assign enc_a   = enc_q[1];
    assign enc_b   = enc_q[0];
    assign src_ext = src_ext_q;
    assign step    = step_q;

endmodule

// File: tb/tb_paddle_quad_encoder.sv
// -----------------------------------------------------------------------------
// tb_paddle_quad_encoder
//
// Bench for paddle_quad_encoder with DIV_MAX=20, DIV_MIN=8, ACCEL_STEP=4 and
// FILT_LEN=4. A behavioural model predicts {enc_a, enc_b, src_ext, step} after
// every clock edge. The model tracks cycles remaining until the next step, a
// phase index into the Gray sequence, and a history of deglitcher samples.
// The directed scenarios also compare step timing and enc values with
// fixed expected numbers.
// -----------------------------------------------------------------------------
module tb_paddle_quad_encoder;

    localparam int DIV_MAX    = 20;
    localparam int DIV_MIN    = 8;
    localparam int ACCEL_STEP = 4;
    localparam int FILT_LEN   = 4;

    logic CLK = 1'b0;
    logic Reset_n, left, right, ext_a, ext_b;
    logic enc_a, enc_b, src_ext, step;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    always #5 CLK = ~CLK;

    paddle_quad_encoder #(
        .DIV_MAX   (DIV_MAX),
        .DIV_MIN   (DIV_MIN),
        .ACCEL_STEP(ACCEL_STEP),
        .FILT_LEN  (FILT_LEN)
    ) dut (
        .CLK    (CLK),
        .Reset_n(Reset_n),
        .left   (left),
        .right  (right),
        .ext_a  (ext_a),
        .ext_b  (ext_b),
        .enc_a  (enc_a),
        .enc_b  (enc_b),
        .src_ext(src_ext),
        .step   (step)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    logic [1:0] phases [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    int         m_remaining;  // clocks until the next step while a direction is held
    int         m_period;
    int         m_idx;        // index into phases
    int         m_prev_dir;   // -1 left, 0 idle, +1 right
    logic [1:0] m_enc;
    logic       m_src;
    logic       m_step;
    logic [1:0] m_filt;
    logic [1:0] m_pipe [2];   // the two synchroniser stages
    logic [1:0] m_hist [$];   // most recent deglitcher samples, newest last

    task automatic model_reset();
        m_remaining = DIV_MAX;
        m_period    = DIV_MAX;
        m_idx       = 0;
        m_prev_dir  = 0;
        m_enc       = 2'b00;
        m_src       = 1'b0;
        m_step      = 1'b0;
        m_filt      = 2'b11;
        m_pipe[0]   = 2'b11;
        m_pipe[1]   = 2'b11;
        m_hist.delete();
    endtask

    task automatic model_step(input logic l, input logic r, input logic [1:0] ext);
        int         dir;
        logic       chg;
        logic       same;
        logic [1:0] x;
        // The output register shows the source and phase from before this edge.
        m_enc = m_src ? m_filt : phases[m_idx];

        dir    = (r && !l) ? 1 : ((l && !r) ? -1 : 0);
        m_step = 1'b0;
        if (dir == 0 || (m_prev_dir != 0 && dir != m_prev_dir)) begin
            m_period    = DIV_MAX;
            m_remaining = DIV_MAX;
        end else begin
            m_remaining--;
            if (m_remaining == 0) begin
                m_step      = 1'b1;
                m_idx       = (m_idx + ((dir > 0) ? 1 : 3)) % 4;
                m_period    = (m_period - ACCEL_STEP < DIV_MIN) ? DIV_MIN : m_period - ACCEL_STEP;
                m_remaining = m_period;
            end
        end
        m_prev_dir = dir;

        chg = 1'b0;
`ifdef PADDLE_QUAD_EXT_EN
        x = m_pipe[1];
        m_hist.push_back(x);
        if (m_hist.size() > FILT_LEN) void'(m_hist.pop_front());
        if (m_hist.size() == FILT_LEN && x != m_filt) begin
            same = 1'b1;
            foreach (m_hist[i]) if (m_hist[i] != x) same = 1'b0;
            if (same) begin
                m_filt = x;
                chg    = 1'b1;
            end
        end
        m_pipe[1] = m_pipe[0];
        m_pipe[0] = ext;
`else
        x    = ext;
        same = 1'b0;
`endif
        if (m_step)   m_src = 1'b0;
        else if (chg) m_src = 1'b1;
    endtask

    // One clock: sample the inputs in front of the edge, advance the model,
    // then compare every output 1 ns after the edge.
    task automatic tick();
        logic       sl, sr, srst;
        logic [1:0] se;
        sl   = left;
        sr   = right;
        se   = {ext_a, ext_b};
        srst = Reset_n;
        @(posedge CLK);
        #1;
        if (!srst) model_reset();
        else       model_step(sl, sr, se);
        cyc++;
        check($sformatf("cyc%0d", cyc), {28'd0, enc_a, enc_b, src_ext, step},
              {28'd0, m_enc, m_src, m_step});
    endtask

    // Pulse reset in the middle of a clock cycle; the outputs must clear at once.
    task automatic do_reset();
        #2;
        Reset_n = 1'b0;
        #1;
        model_reset();
        check("rst_async", {28'd0, enc_a, enc_b, src_ext, step}, 32'd0);
        tick();
        tick();
        Reset_n = 1'b1;
    endtask

    int         steps_q [$];
    logic [1:0] enc_at  [0:80];
    logic       src_at  [0:80];
    int         exp_cyc [6] = '{20, 36, 48, 56, 64, 72};
    logic [1:0] exp_enc [6] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11};

    initial begin
        int         nsteps;
        int         first;
        int         t;
        logic       prev_step;
        logic [1:0] got_enc [2];
        int         ngot;

        Reset_n = 1'b0;
        left    = 1'b0;
        right   = 1'b0;
        ext_a   = 1'b1;
        ext_b   = 1'b1;
        model_reset();
        #3;
        check("rst_init", {28'd0, enc_a, enc_b, src_ext, step}, 32'd0);
        tick();
        tick();
        Reset_n = 1'b1;

        // Hold right: steps at 20,36,48,56,64,72, enc one cycle behind.
        right = 1'b1;
        for (int i = 1; i <= 73; i++) begin
            tick();
            if (step) steps_q.push_back(i);
            enc_at[i] = {enc_a, enc_b};
        end
        check("hold_r_nsteps", steps_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < steps_q.size()) check($sformatf("hold_r_step%0d_cyc", i), steps_q[i], exp_cyc[i]);
            check($sformatf("hold_r_enc%0d", i), {30'd0, enc_at[exp_cyc[i] + 1]}, {30'd0, exp_enc[i]});
            check($sformatf("hold_r_enc%0d_pre", i), {30'd0, enc_at[exp_cyc[i]]},
                  {30'd0, (i == 0) ? 2'b00 : exp_enc[i-1]});
        end

        // Reset mid-run with right still held: no step for 19 cycles, then one.
        for (int i = 0; i < 5; i++) tick();
        do_reset();
        nsteps = 0;
        for (int i = 1; i <= 19; i++) begin
            tick();
            if (step) nsteps++;
        end
        check("rst_quiet_19", nsteps, 0);
        tick();
        check("rst_first_step", {31'd0, step}, 32'd1);

        // Both pressed for 100 cycles is idle; then releasing left steps after 20.
        do_reset();
        left   = 1'b1;
        right  = 1'b1;
        nsteps = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (step) nsteps++;
        end
        check("both_nsteps", nsteps, 0);
        check("both_enc", {30'd0, enc_a, enc_b}, 32'd0);
        left  = 1'b0;
        first = -1;
        for (int i = 1; i <= 25; i++) begin
            tick();
            if (step && first < 0) first = i;
        end
        check("both_release_first", first, 20);

        // Three right steps, then swap to left: phase walks back from 10.
        do_reset();
        left   = 1'b0;
        right  = 1'b1;
        nsteps = 0;
        for (int i = 0; i < 80 && nsteps < 3; i++) begin
            tick();
            if (step) nsteps++;
        end
        check("rev_right_steps", nsteps, 3);
        tick();
        check("rev_enc_before", {30'd0, enc_a, enc_b}, 32'b10);
        left      = 1'b1;
        right     = 1'b0;
        first     = -1;
        ngot      = 0;
        prev_step = 1'b0;
        for (int i = 1; i <= 80 && ngot < 2; i++) begin
            tick();
            if (prev_step) begin
                got_enc[ngot] = {enc_a, enc_b};
                ngot++;
            end
            if (step && first < 0) first = i;
            prev_step = step;
        end
        check("rev_first_step", first, DIV_MAX + 1);
        check("rev_nenc", ngot, 2);
        if (ngot > 0) check("rev_enc0", {30'd0, got_enc[0]}, 32'b11);
        if (ngot > 1) check("rev_enc1", {30'd0, got_enc[1]}, 32'b01);

        // External spinner: a 3-cycle glitch is ignored, a stable change lands in 7.
        left  = 1'b0;
        right = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        ext_a = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        ext_a = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("glitch_src", {31'd0, src_ext}, 32'd0);
        check("glitch_enc", {30'd0, enc_a, enc_b}, 32'd0);
        ext_a = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            enc_at[i] = {enc_a, enc_b};
            src_at[i] = src_ext;
        end
        check("ext_enc_t6", {30'd0, enc_at[6]}, 32'b00);
`ifdef PADDLE_QUAD_EXT_EN
        check("ext_enc_t7", {30'd0, enc_at[7]}, 32'b01);
        check("ext_src_t7", {31'd0, src_at[7]}, 32'd1);
`else
        check("ext_enc_t7", {30'd0, enc_at[7]}, 32'b00);
        check("ext_src_t7", {31'd0, src_at[7]}, 32'd0);
`endif

        // Spinner moves to 10, then right is held: the first step hands the
        // outputs back to the joystick.
        ext_a = 1'b1;
        ext_b = 1'b0;
        for (int i = 0; i < 10; i++) tick();
`ifdef PADDLE_QUAD_EXT_EN
        check("handback_enc_ext", {30'd0, enc_a, enc_b}, 32'b10);
`else
        check("handback_enc_ext", {30'd0, enc_a, enc_b}, 32'b00);
`endif
        right = 1'b1;
        t     = 0;
        for (int i = 1; i <= 21; i++) begin
            tick();
            if (i == 20) begin
                check("handback_step", {31'd0, step}, 32'd1);
                check("handback_src", {31'd0, src_ext}, 32'd0);
            end
            t = i;
        end
        check("handback_enc_joy", {30'd0, enc_a, enc_b}, 32'b01);
        check("handback_cycles", t, 21);

        // Random joystick and spinner activity against the model.
        for (int seg = 0; seg < 70; seg++) begin
            int mode;
            int hold;
            mode  = $urandom_range(0, 3);
            left  = (mode == 2 || mode == 3);
            right = (mode == 1 || mode == 3);
            hold  = $urandom_range(1, 60);
            for (int i = 0; i < hold; i++) begin
                if ($urandom_range(0, 5) == 0) begin
                    ext_a = 1'($urandom);
                    ext_b = 1'($urandom);
                end
                if ($urandom_range(0, 400) == 0) do_reset();
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
